// File: rtl/regfile_scoreboard.sv
// Register file with 2 combinational read ports, 1 write port and per-register busy scoreboard.
// Read latency 0; write/reserve/flush take effect at the rising edge. Same-cycle bypass when REGFILE_BYPASS_EN is defined.
// No backpressure: decode holds dependent instructions using stall.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_reserve,
  input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
  input  logic                  ctrl_flush,
  output logic                  busy_readRegA,
  output logic                  busy_readRegB,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pending_count,
  output logic                  err_sticky
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [CW-1:0]         count_nxt;
  logic                  wr_v, rsv_v, set_new, clr_old, err_nxt;
  logic                  zero_a, zero_b, byp_a, byp_b, bsy_a, bsy_b;

  // Index 0 is hard-wired when ZERO_REG is set: writes and reserves to it vanish.
  assign wr_v   = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
  assign rsv_v  = ctrl_reserve && !((ZERO_REG != 0) && (ctrl_reserveReg == '0));
  assign zero_a = (ZERO_REG != 0) && (ctrl_readRegA == '0);
  assign zero_b = (ZERO_REG != 0) && (ctrl_readRegB == '0);

  always_comb begin
    busy_nxt = busy;
    if (ctrl_flush) begin
      busy_nxt = '0;
    end else if (wr_v) begin
      busy_nxt[ctrl_writeReg] = 1'b0;
    end
    // Reserve is applied last so it wins over both a same-index write and a flush.
    if (rsv_v) begin
      busy_nxt[ctrl_reserveReg] = 1'b1;
    end
  end

  // Incremental popcount tracking; a flush collapses it to the single surviving reserve.
  assign set_new   = rsv_v && !busy[ctrl_reserveReg];
  assign clr_old   = wr_v && busy[ctrl_writeReg] && !(rsv_v && (ctrl_reserveReg == ctrl_writeReg));
  assign count_nxt = ctrl_flush ? CW'(rsv_v)
                                : pending_count + CW'(set_new) - CW'(clr_old);

  assign err_nxt = (rsv_v && busy[ctrl_reserveReg] &&
                    !(wr_v && (ctrl_writeReg == ctrl_reserveReg))) ||
                   (ctrl_writeEnable && (ctrl_writeReg != '0) && !busy[ctrl_writeReg]);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy          <= '0;
      pending_count <= '0;
      err_sticky    <= 1'b0;
    end else begin
      if (wr_v) begin
        regs[ctrl_writeReg] <= data_writeReg;
      end
      busy          <= busy_nxt;
      pending_count <= count_nxt;
      if (err_nxt) begin
        err_sticky <= 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp_a = wr_v && (ctrl_writeReg == ctrl_readRegA);
  assign byp_b = wr_v && (ctrl_writeReg == ctrl_readRegB);
  assign bsy_a = byp_a ? (rsv_v && (ctrl_reserveReg == ctrl_readRegA)) : busy[ctrl_readRegA];
  assign bsy_b = byp_b ? (rsv_v && (ctrl_reserveReg == ctrl_readRegB)) : busy[ctrl_readRegB];
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
  assign bsy_a = busy[ctrl_readRegA];
  assign bsy_b = busy[ctrl_readRegB];
`endif

  assign data_readRegA = (!ctrl_reset_n || zero_a) ? '0 :
                         byp_a ? data_writeReg : regs[ctrl_readRegA];
  assign data_readRegB = (!ctrl_reset_n || zero_b) ? '0 :
                         byp_b ? data_writeReg : regs[ctrl_readRegB];
  assign busy_readRegA = ctrl_reset_n && !zero_a && bsy_a;
  assign busy_readRegB = ctrl_reset_n && !zero_b && bsy_b;
  assign stall         = busy_readRegA | busy_readRegB;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters (32x32, ZERO_REG=1).
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        ctrl_reserve;
  logic [4:0]  ctrl_reserveReg;
  logic        ctrl_flush;
  logic        busy_readRegA;
  logic        busy_readRegB;
  logic        stall;
  logic [5:0]  pending_count;
  logic        err_sticky;

  int n_cmp = 0;
  int n_err = 0;

  regfile_scoreboard dut (
    .clock           (clock),
    .ctrl_reset_n    (ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .ctrl_readRegA   (ctrl_readRegA),
    .ctrl_readRegB   (ctrl_readRegB),
    .data_readRegA   (data_readRegA),
    .data_readRegB   (data_readRegB),
    .ctrl_reserve    (ctrl_reserve),
    .ctrl_reserveReg (ctrl_reserveReg),
    .ctrl_flush      (ctrl_flush),
    .busy_readRegA   (busy_readRegA),
    .busy_readRegB   (busy_readRegB),
    .stall           (stall),
    .pending_count   (pending_count),
    .err_sticky      (err_sticky)
  );

  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ctrl_writeEnable = 1'b0;
    ctrl_reserve     = 1'b0;
    ctrl_flush       = 1'b0;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    idle();
    ctrl_writeReg = '0; data_writeReg = '0; ctrl_reserveReg = '0;
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd7;
    #12;
    chk("rst_dataA", data_readRegA, 32'h0);
    chk("rst_pending", 32'(pending_count), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    ctrl_reset_n = 1'b1;

    // Reset/zero register
    tick();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'hDEADBEEF;
    tick();
    ctrl_writeReg = 5'd7; data_writeReg = 32'h12345678;
    tick();
    idle();
    #1;
    chk("zero_A", data_readRegA, 32'h0);
    chk("r7_B", data_readRegB, 32'h12345678);
    chk("unreserved_r7_err", 32'(err_sticky), 32'd1);
    ctrl_reset_n = 1'b0;
    #1;
    chk("rst_mid_B", data_readRegB, 32'h0);
    chk("rst_mid_pending", 32'(pending_count), 32'd0);
    chk("rst_mid_err", 32'(err_sticky), 32'd0);
    #2 ctrl_reset_n = 1'b1;

    // Reserve / writeback
    tick();
    ctrl_reserve = 1'b1; ctrl_reserveReg = 5'd5;
    tick();
    idle(); ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd0;
    #1;
    chk("rsv_busyA", 32'(busy_readRegA), 32'd1);
    chk("rsv_stall", 32'(stall), 32'd1);
    chk("rsv_pending", 32'(pending_count), 32'd1);
    chk("rsv_r0_busyB", 32'(busy_readRegB), 32'd0);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wb_busy_same_cycle", 32'(busy_readRegA), 32'd0);
`else
    chk("wb_busy_same_cycle", 32'(busy_readRegA), 32'd1);
`endif
    tick();
    idle();
    #1;
    chk("wb_busyA", 32'(busy_readRegA), 32'd0);
    chk("wb_stall", 32'(stall), 32'd0);
    chk("wb_pending", 32'(pending_count), 32'd0);
    chk("wb_dataA", data_readRegA, 32'hA5A5A5A5);
    chk("wb_err", 32'(err_sticky), 32'd0);

    // Bypass
    ctrl_reserve = 1'b1; ctrl_reserveReg = 5'd3;
    tick();
    idle(); ctrl_readRegA = 5'd3;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h0000CAFE;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_cycle", data_readRegA, 32'h0000CAFE);
`else
    chk("byp_same_cycle", data_readRegA, 32'h0);
`endif
    tick();
    idle();
    #1;
    chk("byp_next_cycle", data_readRegA, 32'h0000CAFE);
    chk("byp_pending", 32'(pending_count), 32'd0);

    // Collision: reserve and write same index
    ctrl_reserve = 1'b1; ctrl_reserveReg = 5'd9;
    tick();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h11;
    tick();
    idle(); ctrl_readRegA = 5'd9;
    #1;
    chk("col_data", data_readRegA, 32'h11);
    chk("col_busy", 32'(busy_readRegA), 32'd1);
    chk("col_pending", 32'(pending_count), 32'd1);
    chk("col_err", 32'(err_sticky), 32'd0);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h22;
    tick();
    idle();

    // Reserve of r0 is ignored
    ctrl_reserve = 1'b1; ctrl_reserveReg = 5'd0;
    tick();
    idle(); ctrl_readRegB = 5'd0;
    #1;
    chk("r0_rsv_busy", 32'(busy_readRegB), 32'd0);
    chk("r0_rsv_pending", 32'(pending_count), 32'd0);

    // Flush
    for (int i = 1; i <= 3; i++) begin
      ctrl_reserve = 1'b1; ctrl_reserveReg = 5'(i);
      tick();
    end
    idle();
    #1;
    chk("pre_flush_pending", 32'(pending_count), 32'd3);
    ctrl_flush = 1'b1; ctrl_reserve = 1'b1; ctrl_reserveReg = 5'd4;
    tick();
    idle(); ctrl_readRegA = 5'd1; ctrl_readRegB = 5'd4;
    #1;
    chk("flush_pending", 32'(pending_count), 32'd1);
    chk("flush_r1_busy", 32'(busy_readRegA), 32'd0);
    chk("flush_r4_busy", 32'(busy_readRegB), 32'd1);
    chk("flush_err", 32'(err_sticky), 32'd0);

    // Unreserved writeback error
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd6; data_writeReg = 32'h66;
    tick();
    idle(); ctrl_readRegA = 5'd6;
    #1;
    chk("unres_err", 32'(err_sticky), 32'd1);
    chk("unres_data", data_readRegA, 32'h66);
    tick(); tick();
    chk("err_holds", 32'(err_sticky), 32'd1);
    ctrl_reset_n = 1'b0;
    #1;
    chk("err_cleared", 32'(err_sticky), 32'd0);
    #2 ctrl_reset_n = 1'b1;

    // WAW error
    tick();
    ctrl_reserve = 1'b1; ctrl_reserveReg = 5'd8;
    tick();
    #1;
    chk("waw_first_err", 32'(err_sticky), 32'd0);
    tick();
    idle();
    #1;
    chk("waw_err", 32'(err_sticky), 32'd1);
    chk("waw_pending", 32'(pending_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
